// File: rtl/rsa_modexp_param.sv
// rsa_modexp_param: Montgomery modular exponentiator, result = M^E mod N, byte-wide host register port.
// Ports: clk; reset (async, active-low); we/reg_sel/addr/data_i byte writes (sel 1=M 2=E 3=N);
//        data_o registered byte read (sel 0=result); start/busy/done handshake; err = even modulus.
module rsa_modexp_param #(
    parameter int W   = 256,
    parameter int E_W = W,
    parameter int AW  = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [1:0]    reg_sel,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    data_i,
    output logic [7:0]    data_o,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int CW = $clog2(2 * W + 1);
    localparam int BW = $clog2(E_W);
    typedef enum logic [3:0] {IDLE, CHECK, R2, MBAR, XINIT, SQR, MUL, FINAL, DONE} state_t;
    state_t         state;
    logic [W-1:0]   m, n, result, mb, x;
    logic [E_W-1:0] e;
    logic [W:0]     c;
    logic [W+1:0]   t, t_nx, c2;
    logic [W+2:0]   s;
    logic [CW-1:0]  cnt;
    logic [BW-1:0]  bi;
    logic [W-1:0]   mm_a, mm_b, mm_r;
    logic [7:0]     rd;
    logic           a_bit, e_bit, mm_last, bit_last;
    always_comb begin
        mm_a = (state == SQR || state == MUL || state == FINAL) ? x : state == MBAR ? m : W'(1);
        mm_b = state == SQR ? x : state == MUL ? mb : state == FINAL ? W'(1) : c[W-1:0];
        a_bit = 1'(mm_a >> cnt);
        // one Montgomery step: add A[i]*B, make even with N, halve
        s = (W+3)'(t) + (a_bit ? (W+3)'(mm_b) : '0);
        s = s + (s[0] ? (W+3)'(n) : '0);
        t_nx = (W+2)'(s >> 1);
        mm_r = W'(t >= (W+2)'(n) ? t - (W+2)'(n) : t);
        c2 = {c, 1'b0};
        e_bit = 1'(e >> bi);
        mm_last = cnt == CW'(W);
        bit_last = bi == '0;
        rd = '0;
        for (int k = 0; k < W / 8; k++)
            if (addr == AW'(k))
                rd = reg_sel == 2'd0 ? result[k*8 +: 8] : reg_sel == 2'd1 ? m[k*8 +: 8] :
                     reg_sel == 2'd3 ? n[k*8 +: 8] : 8'h00;
        for (int k = 0; k < E_W / 8; k++)
            if (reg_sel == 2'd2 && addr == AW'(k)) rd = e[k*8 +: 8];
    end
    // operands survive reset and are writable only while idle
    always_ff @(posedge clk) begin
        if (we && state == IDLE) begin
            for (int k = 0; k < W / 8; k++) begin
                if (reg_sel == 2'd1 && addr == AW'(k)) m[k*8 +: 8] <= data_i;
                if (reg_sel == 2'd3 && addr == AW'(k)) n[k*8 +: 8] <= data_i;
            end
            for (int k = 0; k < E_W / 8; k++)
                if (reg_sel == 2'd2 && addr == AW'(k)) e[k*8 +: 8] <= data_i;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            data_o <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            c      <= '0;
            t      <= '0;
            cnt    <= '0;
            bi     <= '0;
            mb     <= '0;
            x      <= '0;
        end else begin
            data_o <= rd;
            done   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= CHECK;
                    busy  <= 1'b1;
                    err   <= 1'b0;
                end
                CHECK: begin
                    c     <= (W+1)'(1);
                    t     <= '0;
                    cnt   <= '0;
                    state <= n[0] ? R2 : DONE;
                    if (!n[0]) begin
                        err    <= 1'b1;
                        result <= '0;
                    end
                end
                R2: begin
                    c     <= c2 >= (W+2)'(n) ? (W+1)'(c2 - (W+2)'(n)) : (W+1)'(c2);
                    cnt   <= cnt == CW'(2 * W - 1) ? '0 : cnt + 1'b1;
                    state <= cnt == CW'(2 * W - 1) ? MBAR : R2;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    if (!mm_last) begin
                        t   <= t_nx;
                        cnt <= cnt + 1'b1;
                    end else begin
                        t   <= '0;
                        cnt <= '0;
                        case (state)
                            MBAR: begin
                                mb    <= mm_r;
                                state <= XINIT;
                            end
                            XINIT: begin
                                x     <= mm_r;
                                bi    <= BW'(E_W - 1);
                                state <= SQR;
                            end
                            SQR: begin
                                x     <= mm_r;
                                state <= e_bit ? MUL : bit_last ? FINAL : SQR;
                                if (!e_bit && !bit_last) bi <= bi - 1'b1;
                            end
                            MUL: begin
                                x     <= mm_r;
                                state <= bit_last ? FINAL : SQR;
                                if (!bit_last) bi <= bi - 1'b1;
                            end
                            default: begin
                                result <= mm_r;
                                state  <= DONE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule
